param_updown_counter: RTL

Parametrised up/down counter with programmable step, parallel load, wrap or saturate mode, and sticky overflow/underflow flags with explicit clear. It serves as the general counting primitive for event counters, timers and address generators, replacing the fixed-width, up-only counters. All state changes happen on the rising edge of clk; reset is synchronous.

---
 rtl/counter_pkg.sv | 31 +++
 rtl/cnt_prescaler.sv | 22 ++
 rtl/param_updown_counter.sv | 70 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared counting types and the next-count helper used by counters and timers.
// Values are carried in 33 bits so any WIDTH up to 32 gets its WIDTH+1-bit intermediate.
package counter_pkg;
    typedef enum logic [0:0] {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;
    localparam logic CNT_DIR_UP = 1'b1;
    localparam logic CNT_DIR_DOWN = 1'b0;
    localparam int CNT_XW = 33;
    typedef struct packed {
        logic ev;
        logic [CNT_XW-1:0] value;
    } cnt_res_t;
    function automatic cnt_res_t next_count(
        input logic [CNT_XW-1:0] count,
        input logic [CNT_XW-1:0] step,
        input logic dir,
        input cnt_mode_e mode,
        input logic [CNT_XW-1:0] max
    );
        cnt_res_t r;
        logic [CNT_XW-1:0] sum;
        sum = count + step;
        if (dir == CNT_DIR_UP) begin
            r.ev = sum > max;
            r.value = !r.ev ? sum : (mode == CNT_SAT) ? max : sum - max - 1'b1;
        end else begin
            r.ev = step > count;
            r.value = !r.ev ? count - step : (mode == CNT_SAT) ? '0 : count + max + 1'b1 - step;
        end
        return r;
    endfunction
endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: counts enabled cycles 0..PRESCALE-1 and ticks on the last one.
// clear restarts the phase; a deasserted enable holds it.
module cnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick = enable && (cnt_q == PW'(PRESCALE - 1));
        cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down counter with step, load, wrap/saturate and sticky boundary flags.
// Define UPDOWN_CNT_PRESCALE_EN to gate counting with a divide-by-PRESCALE enable.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP_W = 4,
    parameter logic [32:0] MAX_VAL = (33'd1 << WIDTH) - 33'd1,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count_out,
    output logic              overflow_out,
    output logic              underflow_out,
    output logic              wrap_pulse,
    output logic              tc
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    logic [WIDTH-1:0] count_q, count_d;
    logic ovf_q, ovf_d, udf_q, udf_d, pulse_q, pulse_d;
    logic tick, do_cnt, ev;
    cnt_res_t res;
`ifdef UPDOWN_CNT_PRESCALE_EN
    cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk(clk), .reset(reset), .enable(enable), .clear(load), .tick(tick)
    );
`else
    assign tick = enable;
`endif
    always_comb begin
        res = next_count(CNT_XW'(count_q), CNT_XW'(step), up_dn, cnt_mode_e'(sat_mode), MAX_VAL);
        do_cnt = tick && (step != '0);
        ev = !load && do_cnt && res.ev;
        count_d = load ? ((load_val > MAX_W) ? MAX_W : load_val) : do_cnt ? WIDTH'(res.value) : count_q;
        // an event on the same edge as clr_flags keeps its flag set
        ovf_d = (ev && up_dn == CNT_DIR_UP) || (ovf_q && !clr_flags);
        udf_d = (ev && up_dn == CNT_DIR_DOWN) || (udf_q && !clr_flags);
        pulse_d = ev;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            pulse_q <= pulse_d;
        end
    end
    assign count_out = count_q;
    assign overflow_out = ovf_q;
    assign underflow_out = udf_q;
    assign wrap_pulse = pulse_q;
    assign tc = up_dn ? (count_q == MAX_W) : (count_q == '0);
    a_params: assert property (@(posedge clk)
        WIDTH >= 2 && WIDTH <= 32 && STEP_W <= WIDTH && MAX_VAL >= 1 && PRESCALE >= 1);
    a_step_range: assert property (@(posedge clk) disable iff (reset)
        !(enable && !load && (CNT_XW'(step) > MAX_VAL + 33'd1)));
endmodule
